// File: rtl/bus_pkg.sv
// Shared types, defaults and helpers for the bus responder block.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ACK  = 2'b10
    } resp_state_e;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 4;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_WAIT_CYCLES = 2;

    // Wide enough for the largest legal wait-state count (255).
    localparam int CNT_W = 8;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/bus_responder_if.sv
// Request/acknowledge bus between an initiator and the bus responder.
interface bus_responder_if
    import bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err, busy
    );

endinterface

// File: rtl/resp_mem.sv
// Word storage with synchronous write and registered read; read data is zero unless a read fires.
module resp_mem
    import bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        mem_d   = mem_q;
        rdata_d = '0;
        if (wr_en) begin
            mem_d[idx] = wdata;
        end
        if (rd_en) begin
            rdata_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// Single-outstanding bus responder: accepts a request in IDLE, inserts WAIT_CYCLES
// wait states, then returns a one-cycle ack with read data or an address error.
module bus_responder
    import bus_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic          clk,
    input  logic          resetn,
    bus_responder_if.slave bus
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DEPTH_U = DEPTH;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    resp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              commit;
    logic              in_range;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              wr_en;
    logic              rd_en;

    // With zero wait states the access commits on the accept edge, so the
    // command comes straight from the bus instead of the capture registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cmd_we    = we_q;
        cmd_addr  = addr_q;
        cmd_wdata = wdata_q;
        commit    = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.req) begin
                    we_d      = bus.we;
                    addr_d    = bus.addr;
                    wdata_d   = bus.wdata;
                    cmd_we    = bus.we;
                    cmd_addr  = bus.addr;
                    cmd_wdata = bus.wdata;
                    busy_d    = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ACK;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        in_range = addr_in_range(32'(cmd_addr), DEPTH_U);
        ack_d    = commit;
        err_d    = commit && !in_range;
        wr_en    = commit && cmd_we && in_range;
        rd_en    = commit && !cmd_we && in_range;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    resp_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .idx    (cmd_addr[IDX_W-1:0]),
        .wdata  (cmd_wdata),
        .rdata  (bus.rdata)
    );

    assign bus.ack  = ack_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench: two responders (2 wait states / 12 words, 0 wait states / 16 words)
// driven with directed and random traffic against a transaction-level reference model.
module tb_bus_responder;
    import bus_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int W_A = 2;
    localparam int D_A = 12;
    localparam int W_B = 0;
    localparam int D_B = 16;

    typedef struct {
        int unsigned       cyc;
        logic              err;
        logic              chk_rd;
        logic [DW-1:0]     rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    int unsigned cyc;
    bit          mon_en;
    int          n_tests;
    int          n_fail;

    exp_t          q0[$];
    exp_t          q1[$];
    int unsigned   free_from [2];
    int unsigned   busy_lo [2];
    int unsigned   busy_hi [2];
    logic [DW-1:0] mref [2][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    bus_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    bus_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D_A), .WAIT_CYCLES(W_A)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_a.slave)
    );

    bus_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D_B), .WAIT_CYCLES(W_B)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_b.slave)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, ack WAIT+1 cycles after accept,
    // next accept possible once the ack cycle has passed.
    task automatic model_issue(input int id, input logic r, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned wc;
        int unsigned dp;
        exp_t e;
        wc = (id == 0) ? W_A : W_B;
        dp = (id == 0) ? D_A : D_B;
        if (r && cyc >= free_from[id]) begin
            e.cyc    = cyc + wc + 1;
            e.err    = 1'b0;
            e.chk_rd = 1'b0;
            e.rdata  = '0;
            if (int'(a) < int'(dp)) begin
                if (w) begin
                    mref[id][a] = d;
                end else begin
                    e.chk_rd = 1'b1;
                    e.rdata  = mref[id][a];
                end
            end else begin
                e.err    = 1'b1;
                e.chk_rd = 1'b1;
            end
            free_from[id] = cyc + wc + 2;
            busy_lo[id]   = cyc + 1;
            busy_hi[id]   = cyc + wc + 1;
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
        end
    endtask

    task automatic step(input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        bus_a.req = ra; bus_a.we = wa; bus_a.addr = aa; bus_a.wdata = da;
        bus_b.req = rb; bus_b.we = wb; bus_b.addr = ab; bus_b.wdata = db;
        if (resetn) begin
            model_issue(0, ra, wa, aa, da);
            model_issue(1, rb, wb, ab, db);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset(input int n);
        int unsigned r;
        r = cyc;
        resetn = 1'b0;
        while (q0.size() > 0 && q0[$].cyc > r) void'(q0.pop_back());
        while (q1.size() > 0 && q1[$].cyc > r) void'(q1.pop_back());
        for (int id = 0; id < 2; id++) begin
            for (int k = 0; k < 16; k++) mref[id][k] = '0;
            free_from[id] = r + n;
            if (busy_hi[id] > r) busy_hi[id] = r;
        end
        idle(n);
        resetn = 1'b1;
    endtask

    task automatic check_dut(input int id, input logic ack, input logic err,
                             input logic [DW-1:0] rdata, input logic busy);
        exp_t  e;
        bit    have;
        string p;
        have = 1'b0;
        p = (id == 0) ? "A" : "B";
        if (id == 0) begin
            if (q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
        end
        chk1({p, " ack"}, ack, have);
        if (have && ack) begin
            chk1({p, " err"}, err, e.err);
            if (e.chk_rd) chkw({p, " rdata"}, rdata, e.rdata);
        end else if (!have) begin
            chkw({p, " idle rdata"}, rdata, '0);
            chk1({p, " idle err"}, err, 1'b0);
        end
        chk1({p, " busy"}, busy, (cyc >= busy_lo[id] && cyc <= busy_hi[id]));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_dut(0, bus_a.ack, bus_a.err, bus_a.rdata, bus_a.busy);
            check_dut(1, bus_b.ack, bus_b.err, bus_b.rdata, bus_b.busy);
        end
    end

    initial begin
        cyc     = 0;
        mon_en  = 1'b0;
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        for (int id = 0; id < 2; id++) begin
            free_from[id] = 0;
            busy_lo[id]   = 1;
            busy_hi[id]   = 0;
            for (int k = 0; k < 16; k++) mref[id][k] = '0;
        end
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        apply_reset(2);

        // Write then read-back on the 2-wait-state responder, plus an unwritten word.
        step(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        idle(4);
        step(1'b1, 1'b0, 4'd3, 32'h0, 1'b0, 1'b0, '0, '0);
        idle(4);
        step(1'b1, 1'b0, 4'd5, 32'h0, 1'b0, 1'b0, '0, '0);
        idle(4);

        // Out-of-range address on the 12-word responder.
        step(1'b1, 1'b1, 4'd13, 32'h12345678, 1'b0, 1'b0, '0, '0);
        idle(4);
        step(1'b1, 1'b0, 4'd13, 32'h0, 1'b0, 1'b0, '0, '0);
        idle(4);

        // Request held high: one accept per IDLE cycle.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'd3, 32'h0, 1'b0, 1'b0, '0, '0);
        idle(4);

        // Reset while a write is waiting: the write must not land.
        step(1'b1, 1'b1, 4'd1, 32'hCAFEF00D, 1'b0, 1'b0, '0, '0);
        apply_reset(2);
        step(1'b1, 1'b0, 4'd1, 32'h0, 1'b0, 1'b0, '0, '0);
        idle(4);

        // Zero-wait-state responder: ack the cycle after the request.
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd0, 32'h0);
        idle(2);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd15, 32'hA5A5_5A5A);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd15, 32'h0);
        idle(3);

        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
        end
        idle(8);

        chkw("A queue drained", 32'(q0.size()), 32'd0);
        chkw("B queue drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
